// File: rtl/cannon_state_pkg.sv
// cannon_state_pkg: state encoding, select bit indices and default geometry shared by the cannon logic
package cannon_state_pkg;
   typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN, CLEAR} state_t;
   localparam int SEL_MOVE = 4;
   localparam int SEL_AIM = 3;
   localparam int SEL_NEW = 2;
   localparam int SEL_DONE = 1;
   localparam int X_W_DEF = 4;
   localparam int X_MAX_DEF = 15;
   localparam int Y_MAX_DEF = 15;
endpackage

// File: rtl/cannon_state_sat_step.sv
// sat_step: +/-1 up/down register that holds at MIN..MAX, with a synchronous clear back to INIT
module sat_step #(
   parameter int W = 4,
   parameter bit SGN = 1'b0,
   parameter int MIN = 0,
   parameter int MAX = 15,
   parameter int INIT = 0
) (
   input logic clk,
   input logic rst_n,
   input logic clr,
   input logic inc,
   input logic dec,
   output logic [W-1:0] q
);
   localparam logic signed [W:0] LO = (W + 1)'(MIN);
   localparam logic signed [W:0] HI = (W + 1)'(MAX);
   logic signed [W:0] v;
   assign v = {SGN & q[W-1], q};
   // step once per unopposed pulse, never crossing the bounds
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= W'(INIT);
      else if (clr) q <= W'(INIT);
      else if (inc && !dec && v < HI) q <= q + 1'b1;
      else if (dec && !inc && v > LO) q <= q - 1'b1;
endmodule

// File: rtl/cannon_state.sv
// cannon_state: cannon column, aim and projectile flight sequencer driven by controls command pulses
module cannon_state
   import cannon_state_pkg::*;
#(
   parameter int X_W = X_W_DEF,
   parameter int X_MAX = X_MAX_DEF,
   parameter int Y_MAX = Y_MAX_DEF,
   parameter int AIM_MAX = 2,
   parameter int STEP_DIV = 4,
   parameter int COOL = 8
) (
   input logic clk,
   input logic rst_n,
   input logic left_x,
   input logic right_x,
   input logic left_aim,
   input logic right_aim,
   input logic shoot_out,
   input logic [4:0] select,
   output logic [X_W-1:0] player_x,
   output logic [2:0] aim,
   output logic [X_W-1:0] proj_x,
   output logic [X_W-1:0] proj_y,
   output logic proj_active,
   output logic [7:0] shots,
   output logic clearing
);
   localparam int CW = $clog2((COOL > STEP_DIV ? COOL : STEP_DIV) + 1);
   localparam logic signed [X_W:0] XM = (X_W + 1)'(X_MAX);
   state_t state;
   logic [CW-1:0] cnt;
   logic clr, stay_clr, shoot_q, move_en, aim_en, step, out_x, sel_unused;
   logic signed [X_W:0] nx;
   logic [X_W-1:0] ny;
   assign sel_unused = select[0];
   // qualify commands against the select class and state; precompute the next projectile cell
   always_comb begin
      clr = select[SEL_NEW] || state == CLEAR;
      stay_clr = select[SEL_NEW] || !select[SEL_DONE];
      shoot_q = state == IDLE && shoot_out && select[4:1] == 4'b0;
      move_en = !clr && !shoot_q && select[SEL_MOVE] && (state == IDLE || state == COOLDOWN);
      aim_en = !clr && !shoot_q && select[SEL_AIM] && state == IDLE;
      step = state == FLIGHT && cnt == CW'(STEP_DIV - 1);
      nx = $signed({1'b0, proj_x}) + $signed({{(X_W - 2){aim[2]}}, aim});
      out_x = nx[X_W] || nx > XM;
      ny = proj_y + 1'b1;
   end
   sat_step #(.W(X_W), .SGN(1'b0), .MIN(0), .MAX(X_MAX), .INIT(X_MAX / 2)) u_player (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .inc(move_en && right_x), .dec(move_en && left_x), .q(player_x)
   );
   sat_step #(.W(3), .SGN(1'b1), .MIN(-AIM_MAX), .MAX(AIM_MAX), .INIT(0)) u_aim (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .inc(aim_en && right_aim), .dec(aim_en && left_aim), .q(aim)
   );
   // game FSM: shot launch, timed projectile steps, cooldown and new-game clear
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         proj_x <= '0;
         proj_y <= '0;
         proj_active <= 1'b0;
         shots <= '0;
         clearing <= 1'b0;
      end else if (clr) begin
         state <= stay_clr ? CLEAR : IDLE;
         clearing <= stay_clr;
         cnt <= '0;
         proj_x <= '0;
         proj_y <= '0;
         proj_active <= 1'b0;
         shots <= '0;
      end else
         case (state)
            IDLE:
               if (shoot_q) begin
                  state <= FLIGHT;
                  cnt <= '0;
                  proj_x <= player_x;
                  proj_y <= '0;
                  proj_active <= 1'b1;
                  shots <= shots + 1'b1;
               end
            FLIGHT: begin
               cnt <= step ? '0 : cnt + 1'b1;
               if (step && !out_x) begin
                  proj_x <= nx[X_W-1:0];
                  proj_y <= ny;
               end
               if (step && (out_x || ny == X_W'(Y_MAX))) begin
                  proj_active <= 1'b0;
                  state <= COOLDOWN;
               end
            end
            COOLDOWN: begin
               cnt <= cnt == CW'(COOL - 1) ? '0 : cnt + 1'b1;
               if (cnt == CW'(COOL - 1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_cannon_state.sv
// tb_cannon_state: directed stimulus with a queued expected-snapshot scoreboard for cannon_state
module tb_cannon_state;
   localparam logic [4:0] LX = 5'b10000, RX = 5'b01000, LA = 5'b00100, RA = 5'b00010, SH = 5'b00001;
   localparam logic [4:0] MV = 5'b10000, AM = 5'b01000, NEW = 5'b00100, DONE = 5'b00010;
   typedef struct {
      int cyc;
      string nm;
      logic [3:0] px;
      logic signed [2:0] aim;
      logic [3:0] x;
      logic [3:0] y;
      logic act;
      logic [7:0] sh;
      logic clr;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic left_x = 0, right_x = 0, left_aim = 0, right_aim = 0, shoot_out = 0;
   logic [4:0] select = '0;
   logic [3:0] player_x, proj_x, proj_y;
   logic [2:0] aim;
   logic proj_active, clearing;
   logic [7:0] shots;
   int cyc = 0, nvec = 0, nerr = 0;
   exp_t q[$];
   exp_t m;
   logic [3:0] e_px = 7, e_x = 0, e_y = 0;
   logic signed [2:0] e_aim = 0;
   logic e_act = 0, e_clr = 0;
   logic [7:0] e_sh = 0;

   cannon_state dut (
      .clk(clk), .rst_n(rst_n), .left_x(left_x), .right_x(right_x), .left_aim(left_aim),
      .right_aim(right_aim), .shoot_out(shoot_out), .select(select), .player_x(player_x),
      .aim(aim), .proj_x(proj_x), .proj_y(proj_y), .proj_active(proj_active), .shots(shots),
      .clearing(clearing)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compare every due snapshot on the falling edge, away from the active edge
   always @(negedge clk)
      while (q.size() != 0 && q[0].cyc <= cyc) begin
         m = q.pop_front();
         nvec++;
         if ({player_x, aim, proj_x, proj_y, proj_active, shots, clearing} !==
             {m.px, m.aim, m.x, m.y, m.act, m.sh, m.clr}) begin
            nerr++;
            $display("FAIL %s @%0d: got px=%0d aim=%0d x=%0d y=%0d act=%0b shots=%0d clr=%0b, want px=%0d aim=%0d x=%0d y=%0d act=%0b shots=%0d clr=%0b",
               m.nm, cyc, player_x, $signed(aim), proj_x, proj_y, proj_active, shots, clearing,
               m.px, m.aim, m.x, m.y, m.act, m.sh, m.clr);
         end
      end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, %0d entries pending", q.size());
      $fatal(1, "timeout");
   end

   task automatic drive(input logic [4:0] p, input logic [4:0] sel);
      {left_x, right_x, left_aim, right_aim, shoot_out} = p;
      select = sel;
      @(posedge clk);
      #1;
      {left_x, right_x, left_aim, right_aim, shoot_out} = '0;
      select = '0;
   endtask

   task automatic expect_now(input string nm);
      q.push_back('{cyc, nm, e_px, e_aim, e_x, e_y, e_act, e_sh, e_clr});
   endtask

   task automatic reset_exp();
      e_px = 7; e_aim = 0; e_x = 0; e_y = 0; e_act = 0; e_sh = 0; e_clr = 0;
   endtask

   initial begin
      #23 rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_now("reset");
      for (int i = 0; i < 3; i++) begin drive(LX, MV); e_px--; expect_now("move_left"); end
      drive(LX, 5'b0); expect_now("move_unqualified");
      drive(LX, AM); expect_now("move_wrong_class");
      drive(LX | RX, MV); expect_now("move_opposing");
      for (int i = 0; i < 12; i++) begin
         drive(RX, MV);
         if (e_px != 15) e_px++;
         expect_now("move_right_sat");
      end
      for (int i = 0; i < 11; i++) begin drive(LX, MV); e_px--; expect_now("move_back"); end
      for (int i = 0; i < 3; i++) begin
         drive(RA, AM);
         if (e_aim != 2) e_aim++;
         expect_now("aim_right_sat");
      end
      drive(LA | RA, AM); expect_now("aim_opposing");
      drive(LA, MV); expect_now("aim_wrong_class");
      drive(LA, AM); e_aim = 1; expect_now("aim_left");
      drive(SH, DONE); expect_now("shoot_unqualified");
      drive(SH, 5'b00001); e_x = 4; e_y = 0; e_act = 1; e_sh = 1; expect_now("shoot");
      for (int k = 1; k <= 48; k++) begin
         drive(k == 2 ? SH : k == 3 ? LA : k == 5 ? RX : k == 7 ? RA : 5'b0,
               (k == 3 || k == 7) ? AM : k == 5 ? MV : 5'b0);
         if (k % 4 == 0) begin
            if (k == 48) e_act = 0;
            else begin e_x++; e_y++; end
         end
         expect_now("flight");
      end
      for (int k = 1; k <= 9; k++) begin
         drive(k == 4 ? RX : k == 6 ? SH : (k == 2 || k == 8 || k == 9) ? RA : 5'b0,
               k == 4 ? MV : (k == 2 || k == 8 || k == 9) ? AM : 5'b0);
         if (k == 4) e_px = 5;
         if (k == 9) e_aim = 2;
         expect_now("cooldown");
      end
      drive(SH, 5'b0); e_x = 5; e_y = 0; e_act = 1; e_sh = 2; expect_now("shoot2");
      for (int k = 1; k <= 4; k++) begin
         drive(5'b0, 5'b0);
         if (k == 4) begin e_x = 7; e_y = 1; end
         expect_now("flight2");
      end
      drive(5'b0, NEW); reset_exp(); e_clr = 1; expect_now("clear_enter");
      drive(RX, MV); expect_now("clear_ignore_move");
      drive(SH, 5'b0); expect_now("clear_ignore_shoot");
      drive(5'b0, NEW | DONE); expect_now("clear_new_held");
      drive(5'b0, DONE); e_clr = 0; expect_now("clear_exit");
      drive(5'b0, DONE); expect_now("done_outside_clear");
      for (int i = 0; i < 8; i++) begin
         drive(LX, MV);
         if (e_px != 0) e_px--;
         expect_now("move_left_sat");
      end
      drive(SH, 5'b0); e_x = 0; e_y = 0; e_act = 1; e_sh = 1; expect_now("shoot3");
      drive(5'b0, 5'b0);
      drive(5'b0, 5'b0);
      #1 rst_n = 1'b0;
      reset_exp();
      expect_now("async_reset");
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin drive(LA, AM); e_aim--; expect_now("aim_left_sat"); end
      for (int i = 0; i < 7; i++) begin drive(LX, MV); e_px--; expect_now("move_to_zero"); end
      for (int i = 1; i <= 256; i++) begin
         drive(SH, 5'b0);
         e_sh++; e_x = 0; e_y = 0; e_act = 1;
         expect_now("shots");
         repeat (12) drive(5'b0, 5'b0);
         e_act = 0;
         expect_now("shots_idle");
      end
      repeat (2) @(negedge clk);
      nvec++;
      if (q.size() != 0) begin
         nerr++;
         $display("FAIL drain: got %0d pending entries, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
